// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master: single-outstanding command-to-AXI4-Lite master with response handshake and error count
module axi_lite_cmd_master #(
   parameter int C_M0_axi_ADDR_WIDTH = 4,
   parameter int C_M0_axi_DATA_WIDTH = 32
) (
   input  logic                                 M0_axi_aclk,
   input  logic                                 M0_axi_aresetn,
   input  logic                                 cmd_valid,
   output logic                                 cmd_ready,
   input  logic                                 cmd_write,
   input  logic [C_M0_axi_ADDR_WIDTH-1:0]       cmd_addr,
   input  logic [C_M0_axi_DATA_WIDTH-1:0]       cmd_wdata,
   input  logic [C_M0_axi_DATA_WIDTH/8-1:0]     cmd_wstrb,
   output logic                                 rsp_valid,
   input  logic                                 rsp_ready,
   output logic                                 rsp_write,
   output logic [C_M0_axi_DATA_WIDTH-1:0]       rsp_data,
   output logic [1:0]                           rsp_resp,
   output logic                                 busy,
   output logic [7:0]                           err_count,
   output logic [C_M0_axi_ADDR_WIDTH-1:0]       M0_axi_awaddr,
   output logic [2:0]                           M0_axi_awprot,
   output logic                                 M0_axi_awvalid,
   input  logic                                 M0_axi_awready,
   output logic [C_M0_axi_DATA_WIDTH-1:0]       M0_axi_wdata,
   output logic [C_M0_axi_DATA_WIDTH/8-1:0]     M0_axi_wstrb,
   output logic                                 M0_axi_wvalid,
   input  logic                                 M0_axi_wready,
   input  logic [1:0]                           M0_axi_bresp,
   input  logic                                 M0_axi_bvalid,
   output logic                                 M0_axi_bready,
   output logic [C_M0_axi_ADDR_WIDTH-1:0]       M0_axi_araddr,
   output logic [2:0]                           M0_axi_arprot,
   output logic                                 M0_axi_arvalid,
   input  logic                                 M0_axi_arready,
   input  logic [C_M0_axi_DATA_WIDTH-1:0]       M0_axi_rdata,
   input  logic [1:0]                           M0_axi_rresp,
   input  logic                                 M0_axi_rvalid,
   output logic                                 M0_axi_rready
);
   localparam int AW = C_M0_axi_ADDR_WIDTH;
   localparam int DW = C_M0_axi_DATA_WIDTH;
   localparam int SW = DW / 8;
   typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;
   state_t state, state_n;
   logic awvalid_q, wvalid_q, arvalid_q;
   logic awvalid_n, wvalid_n, arvalid_n;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [SW-1:0] wstrb_q;
   logic accept, cap_b, cap_r, cap_err;
   assign accept  = state == IDLE && cmd_valid;
   assign cap_b   = state == WR_B && M0_axi_bvalid;
   assign cap_r   = state == RD_R && M0_axi_rvalid;
   assign cap_err = (cap_b && M0_axi_bresp[1]) || (cap_r && M0_axi_rresp[1]);
   always_comb begin
      state_n   = state;
      awvalid_n = awvalid_q;
      wvalid_n  = wvalid_q;
      arvalid_n = arvalid_q;
      case (state)
         IDLE: if (cmd_valid) begin
            state_n   = cmd_write ? WR_AW_W : RD_AR;
            awvalid_n = cmd_write;
            wvalid_n  = cmd_write;
            arvalid_n = !cmd_write;
         end
         WR_AW_W: begin
            awvalid_n = awvalid_q && !M0_axi_awready;
            wvalid_n  = wvalid_q && !M0_axi_wready;
            state_n   = (awvalid_n || wvalid_n) ? WR_AW_W : WR_B;
         end
         WR_B: state_n = M0_axi_bvalid ? RSP : WR_B;
         RD_AR: begin
            arvalid_n = !M0_axi_arready;
            state_n   = M0_axi_arready ? RD_R : RD_AR;
         end
         RD_R: state_n = M0_axi_rvalid ? RSP : RD_R;
         RSP: state_n = rsp_ready ? IDLE : RSP;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge M0_axi_aclk) begin
      if (!M0_axi_aresetn) begin
         state     <= IDLE;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rsp_write <= 1'b0;
         rsp_resp  <= 2'b00;
         rsp_data  <= '0;
         err_count <= 8'd0;
      end else begin
         state     <= state_n;
         awvalid_q <= awvalid_n;
         wvalid_q  <= wvalid_n;
         arvalid_q <= arvalid_n;
         if (accept) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
         end
         if (cap_b || cap_r) begin
            rsp_write <= cap_b;
            rsp_resp  <= cap_b ? M0_axi_bresp : M0_axi_rresp;
            rsp_data  <= cap_b ? '0 : M0_axi_rdata;
         end
         if (cap_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
   end
   assign cmd_ready      = state == IDLE;
   assign busy           = state != IDLE;
   assign rsp_valid      = state == RSP;
   assign M0_axi_awaddr  = addr_q;
   assign M0_axi_araddr  = addr_q;
   assign M0_axi_awprot  = 3'b000;
   assign M0_axi_arprot  = 3'b000;
   assign M0_axi_awvalid = awvalid_q;
   assign M0_axi_wvalid  = wvalid_q;
   assign M0_axi_wdata   = wdata_q;
   assign M0_axi_wstrb   = wstrb_q;
   assign M0_axi_arvalid = arvalid_q;
   assign M0_axi_bready  = state == WR_B;
   assign M0_axi_rready  = state == RD_R;
endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb_axi_lite_cmd_master: directed bench with a delay-configurable slave and a transaction-level response model
module tb_axi_lite_cmd_master;
   logic clk, aresetn;
   logic cmd_valid, cmd_ready, cmd_write;
   logic [3:0] cmd_addr, cmd_wstrb;
   logic [31:0] cmd_wdata;
   logic rsp_valid, rsp_ready, rsp_write, busy;
   logic [31:0] rsp_data;
   logic [1:0] rsp_resp;
   logic [7:0] err_count;
   logic [3:0] awaddr, araddr, wstrb;
   logic [2:0] awprot, arprot;
   logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [1:0] bresp, rresp;
   int aw_dly, w_dly, ar_dly, b_dly, r_dly;
   int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
   logic spur_b, spur_r;
   int n_checks, n_fail;
   logic [34:0] q[$];
   logic [3:0] cur_addr, cur_strb;
   logic [31:0] cur_wdata;
   int exp_err;

   axi_lite_cmd_master dut (
      .M0_axi_aclk(clk), .M0_axi_aresetn(aresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_data(rsp_data), .rsp_resp(rsp_resp), .busy(busy), .err_count(err_count),
      .M0_axi_awaddr(awaddr), .M0_axi_awprot(awprot), .M0_axi_awvalid(awvalid), .M0_axi_awready(awready),
      .M0_axi_wdata(wdata), .M0_axi_wstrb(wstrb), .M0_axi_wvalid(wvalid), .M0_axi_wready(wready),
      .M0_axi_bresp(bresp), .M0_axi_bvalid(bvalid), .M0_axi_bready(bready),
      .M0_axi_araddr(araddr), .M0_axi_arprot(arprot), .M0_axi_arvalid(arvalid), .M0_axi_arready(arready),
      .M0_axi_rdata(rdata), .M0_axi_rresp(rresp), .M0_axi_rvalid(rvalid), .M0_axi_rready(rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // slave: each ready/valid fires once its partner has waited the configured number of cycles
   assign awready = awvalid && aw_cnt >= aw_dly;
   assign wready  = wvalid && w_cnt >= w_dly;
   assign arready = arvalid && ar_cnt >= ar_dly;
   assign bvalid  = spur_b || (bready && b_cnt >= b_dly);
   assign rvalid  = spur_r || (rready && r_cnt >= r_dly);
   always @(posedge clk) begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      b_cnt  <= (bready && !bvalid) ? b_cnt + 1 : 0;
      r_cnt  <= (rready && !rvalid) ? r_cnt + 1 : 0;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // compare process: response scoreboard, saturating error model and per-cycle channel rules
   initial begin
      int aw_n, w_n, b_n, ar_n, r_n;
      logic hold;
      logic [34:0] h_payload, e;
      aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0; hold = 0; h_payload = '0; exp_err = 0;
      forever begin
         @(negedge clk);
         if (!aresetn) begin
            q.delete();
            exp_err = 0;
            aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0; hold = 0;
         end else begin
            chk("cmd_ready_vs_busy", cmd_ready, !busy);
            chk("err_count", err_count, exp_err);
            chk("prot", {awprot, arprot}, 6'd0);
            if (awvalid) chk("awaddr", awaddr, cur_addr);
            if (wvalid) chk("wdata_wstrb", {wstrb, wdata}, {cur_strb, cur_wdata});
            if (arvalid) chk("araddr", araddr, cur_addr);
            if (hold) chk("rsp_stable", {rsp_valid, rsp_write, rsp_resp, rsp_data}, {1'b1, h_payload});
            if (bready || rready) chk("ready_after_addr", {awvalid, wvalid, arvalid}, 3'b000);
            if (rsp_valid && rsp_ready) begin
               chk("rsp_expected", q.size() != 0, 1'b1);
               if (q.size() != 0) begin
                  e = q.pop_front();
                  chk("rsp_payload", {rsp_write, rsp_resp, rsp_data}, e);
                  if (rsp_write) chk("wr_handshakes", aw_n * 100 + w_n * 10 + b_n, 111);
                  else chk("rd_handshakes", ar_n * 10 + r_n, 11);
               end
               aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
            end
            if (awvalid && awready) aw_n++;
            if (wvalid && wready) w_n++;
            if (bvalid && bready) b_n++;
            if (arvalid && arready) ar_n++;
            if (rvalid && rready) r_n++;
            if ((bvalid && bready && bresp[1]) || (rvalid && rready && rresp[1]))
               exp_err = exp_err == 255 ? 255 : exp_err + 1;
            hold = rsp_valid && !rsp_ready;
            h_payload = {rsp_write, rsp_resp, rsp_data};
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      logic acc;
      int n;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      cur_addr = a; cur_wdata = d; cur_strb = s;
      acc = 1'b0; n = 0;
      while (!acc && n < 100) begin
         acc = cmd_ready;
         step();
         n++;
      end
      cmd_valid = 1'b0;
      chk("cmd_accept", acc, 1'b1);
      if (acc) q.push_back(w ? {1'b1, bresp, 32'h0} : {1'b0, rresp, rdata});
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 100) begin
         step();
         n++;
      end
      chk("idle_timeout", busy, 1'b0);
   endtask

   task automatic wait_rsp();
      int n;
      n = 0;
      while (!rsp_valid && n < 100) begin
         step();
         n++;
      end
      chk("rsp_timeout", rsp_valid, 1'b1);
   endtask

   task automatic do_cmd(input logic w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      issue(w, a, d, s);
      wait_idle();
   endtask

   initial begin
      int n;
      n_checks = 0; n_fail = 0;
      aresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
      rsp_ready = 1'b1; aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0;
      spur_b = 1'b0; spur_r = 1'b0; bresp = 2'b00; rresp = 2'b00; rdata = '0;
      cur_addr = '0; cur_wdata = '0; cur_strb = '0;
      repeat (2) step();
      aresetn = 1'b1;
      chk("reset_ctrl", {cmd_ready, busy, rsp_valid, awvalid, wvalid, arvalid, bready, rready}, 8'b1000_0000);
      chk("reset_rsp", {err_count, rsp_write, rsp_resp, rsp_data}, 43'd0);
      chk("reset_regs", {awaddr, araddr, wstrb, wdata}, 44'd0);
      step();

      issue(1'b1, 4'h4, 32'hDEADBEEF, 4'hF);
      chk("wr_c1_valids", {awvalid, wvalid, arvalid, awaddr, wdata}, {3'b110, 4'h4, 32'hDEADBEEF});
      step();
      chk("wr_c2_bready", {awvalid, wvalid, bready}, 3'b001);
      step();
      chk("wr_c3_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_data, err_count}, {1'b1, 1'b1, 2'b00, 32'h0, 8'd0});
      wait_idle();

      w_dly = 3;
      issue(1'b1, 4'h2, 32'h01020304, 4'h6);
      step();
      chk("wlag_c2", {awvalid, wvalid, bready}, 3'b010);
      step(); step();
      chk("wlag_c4", {awvalid, wvalid, bready}, 3'b010);
      step();
      chk("wlag_c5", {awvalid, wvalid, bready}, 3'b001);
      step();
      chk("wlag_c6", {rsp_valid, rsp_write, rsp_resp}, 4'b1100);
      wait_idle();
      w_dly = 0;

      ar_dly = 2; rdata = 32'h12345678;
      issue(1'b0, 4'h8, 32'h0, 4'h0);
      step();
      chk("rd_c2_ar", {arvalid, araddr, rready}, {1'b1, 4'h8, 1'b0});
      step(); step();
      chk("rd_c4_rready", {arvalid, rready}, 2'b01);
      step();
      chk("rd_c5_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_data}, {1'b1, 1'b0, 2'b00, 32'h12345678});
      wait_idle();
      ar_dly = 0;

      aw_dly = 2; bresp = 2'b11;
      do_cmd(1'b1, 4'h1, 32'h55AA55AA, 4'h5);
      chk("decerr_count", err_count, 8'd1);
      aw_dly = 0; bresp = 2'b00;

      spur_b = 1'b1; spur_r = 1'b1; bresp = 2'b10; rdata = 32'hA5A5A5A5; ar_dly = 1;
      repeat (3) step();
      chk("spur_idle", {busy, rsp_valid, err_count}, {2'b00, 8'd1});
      do_cmd(1'b0, 4'h3, 32'h0, 4'h0);
      chk("spur_err", err_count, 8'd1);
      spur_b = 1'b0; spur_r = 1'b0; bresp = 2'b00; ar_dly = 0;

      rsp_ready = 1'b0;
      issue(1'b1, 4'hC, 32'h0BADF00D, 4'h3);
      wait_rsp();
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'hF;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("hold_rsp", {rsp_valid, cmd_ready, arvalid, awvalid}, 4'b1000);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      step();
      chk("hold_release", {rsp_valid, cmd_ready, busy}, 3'b010);

      b_dly = 5;
      issue(1'b1, 4'h6, 32'h77777777, 4'hF);
      n = 0;
      while (!bready && n < 50) begin
         step();
         n++;
      end
      chk("reach_wr_b", bready, 1'b1);
      aresetn = 1'b0;
      step();
      aresetn = 1'b1;
      chk("rst_mid_ctrl", {cmd_ready, busy, rsp_valid, awvalid, wvalid, arvalid, bready, rready}, 8'b1000_0000);
      chk("rst_mid_rsp", {err_count, rsp_write, rsp_resp, rsp_data, awaddr, wdata}, 79'd0);
      b_dly = 0; rdata = 32'hCAFEF00D;
      issue(1'b0, 4'h9, 32'h0, 4'h0);
      wait_rsp();
      chk("post_rst_read", {rsp_write, rsp_resp, rsp_data}, {1'b0, 2'b00, 32'hCAFEF00D});
      wait_idle();

      rresp = 2'b10; rdata = 32'h0000BEEF;
      for (int i = 1; i <= 257; i++) begin
         do_cmd(1'b0, 4'h5, 32'h0, 4'h0);
         if (i == 254) chk("err_254", err_count, 8'd254);
         if (i == 255) chk("err_255", err_count, 8'd255);
      end
      chk("err_sat", err_count, 8'd255);
      rresp = 2'b00;
      step();
      chk("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/axi_lite_cmd_master.md
AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master

Interface
REQ-001 Parameter C_M0_axi_ADDR_WIDTH, default 4, AXI4-Lite address width.
REQ-002 Parameter C_M0_axi_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset: M0_axi_aclk input 1 (clock, all logic rising-edge), M0_axi_aresetn input 1 (synchronous active-low reset).
REQ-004 cmd_valid in 1 / cmd_ready out 1 -- command handshake.
REQ-005 cmd_write in 1 (1=write, 0=read); cmd_addr in ADDR_WIDTH; cmd_wdata in DATA_WIDTH; cmd_wstrb in DATA_WIDTH/8.
REQ-006 rsp_valid out 1 / rsp_ready in 1 -- response handshake; rsp_write out 1; rsp_data out DATA_WIDTH; rsp_resp out 2.
REQ-007 busy out 1 (state != IDLE); err_count out 8 (saturating error count).
REQ-008 AXI4-Lite master: M0_axi_awaddr/awprot(3)/awvalid out, awready in; wdata/wstrb/wvalid out, wready in; bresp(2)/bvalid in, bready out; araddr/arprot(3)/arvalid out, arready in; rdata/rresp(2)/rvalid in, rready out.

Function
REQ-009 The block SHALL hold one transaction at a time; states IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
REQ-010 cmd_ready SHALL be 1 only in IDLE; cmd_valid&&cmd_ready registers cmd_write/addr/wdata/wstrb; next state WR_AW_W if write, else RD_AR.
REQ-011 In WR_AW_W, awvalid and wvalid SHALL both be 1 on entry and each SHALL deassert the cycle after its own handshake (ready&&valid), independently of the other.
REQ-012 WR_AW_W SHALL exit to WR_B once both handshakes are done, including both completing in the same cycle; bready SHALL be 1 only in WR_B.
REQ-013 In WR_B, bvalid SHALL capture bresp into rsp_resp, set rsp_data=0 and rsp_write=1, and go to RSP.
REQ-014 In RD_AR, arvalid SHALL be 1 until arvalid&&arready, then RD_R; rready SHALL be 1 only in RD_R.
REQ-015 In RD_R, rvalid SHALL capture rdata/rresp and set rsp_write=0, then RSP.
REQ-016 In RSP, rsp_valid SHALL be 1 with payload stable until rsp_ready, then IDLE; rsp_valid is 0 in all other states.
REQ-017 awaddr/araddr/wdata/wstrb SHALL be registered and stable while their valid is high; awprot=arprot=3'b000 always.
REQ-018 A valid SHALL NOT depend combinationally on any ready; no AXI output SHALL be combinational from AXI inputs.
REQ-019 err_count SHALL increment by 1 when a response with resp[1]=1 (SLVERR/DECERR) is captured, saturating at 255.
REQ-020 Minimum latency with ready slave: command accepted cycle 0, aw/w or ar valid cycle 1, rsp_valid cycle 3.
REQ-021 cmd inputs SHALL be ignored while cmd_ready=0; bvalid/rvalid outside WR_B/RD_R SHALL be ignored.

Reset
REQ-022 With M0_axi_aresetn low at a clock edge, next cycle: state IDLE, awvalid=wvalid=arvalid=bready=rready=0, rsp_valid=0, cmd_ready=1, busy=0, err_count=0, rsp_data=0, rsp_resp=0, rsp_write=0, address/data registers 0.
REQ-023 Reset mid-transaction SHALL abandon the transaction with no response issued; the first post-reset command SHALL proceed normally.

Verification
REQ-024 Write addr 0x4, data 0xDEADBEEF, strb 0xF, slave always ready, bresp=00 -> aw/w valid cycle 1, rsp_valid cycle 3, rsp_write=1, rsp_resp=00, err_count=0.
REQ-025 Write with wready 3 cycles after awready -> awvalid drops after its handshake, wvalid held until wready, single bready phase, one response.
REQ-026 Read addr 0x8, arready delayed 2 cycles, rdata 0x12345678 rresp 00 -> rsp_data=0x12345678, rsp_write=0, araddr stable throughout.
REQ-027 Read with rresp=10 repeated 257 times -> err_count reaches 255 and holds.
REQ-028 rsp_ready held 0 for 5 cycles -> rsp_valid/payload stable, cmd_ready=0, new cmd_valid ignored until rsp accepted.
REQ-029 Reset asserted while in WR_B -> all valids/readies 0 next cycle, no rsp_valid, following read completes correctly.
